// File: rtl/computer_cluster_port.sv
// Cluster port: round-robin arbitration of local cores onto one outgoing data-plane link,
// and per-core show-ahead receive FIFOs fed from the incoming link.
module computer_cluster_port #(
    parameter int NUM_CORES = 4,
    parameter int RX_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               node_id,
    input  logic [NUM_CORES-1:0]      core_tx_req,
    input  logic [NUM_CORES*8-1:0]    core_tx_dest_node,
    input  logic [NUM_CORES*4-1:0]    core_tx_dest_core,
    input  logic [NUM_CORES*16-1:0]   core_tx_data,
    output logic [NUM_CORES-1:0]      core_tx_ack,
    output logic [31:0]               data_tx_packet,
    output logic                      data_tx_valid,
    input  logic                      data_tx_ready,
    input  logic [31:0]               data_rx_packet,
    input  logic                      data_rx_valid,
    output logic [NUM_CORES-1:0]      core_rx_valid,
    output logic [NUM_CORES*16-1:0]   core_rx_data,
    output logic [NUM_CORES*4-1:0]    core_rx_src_core,
    input  logic [NUM_CORES-1:0]      core_rx_read,
    output logic [15:0]               rx_drop_count
);
    localparam int AW = $clog2(RX_DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} tx_state_t;

    tx_state_t              state_r;
    logic [3:0]             rr_ptr_r;
    logic [3:0]             grant_r;
    logic [31:0]            tx_packet_r;
    logic                   tx_valid_r;
    logic [NUM_CORES-1:0]   tx_ack_r;

    logic                   found_s;
    logic [3:0]             grant_s;
    logic [NUM_CORES-1:0]   onehot_s;
    logic [31:0]            grant_pkt_s;
    int                     idx_s;

    // Round-robin search: first requester at or after rr_ptr, wrapping modulo NUM_CORES.
    always_comb begin
        found_s     = 1'b0;
        grant_s     = 4'd0;
        onehot_s    = {NUM_CORES{1'b0}};
        grant_pkt_s = 32'd0;
        idx_s       = 0;
        for (int off = 0; off < NUM_CORES; off++) begin
            idx_s = (int'(rr_ptr_r) + off >= NUM_CORES) ? int'(rr_ptr_r) + off - NUM_CORES
                                                        : int'(rr_ptr_r) + off;
            for (int c = 0; c < NUM_CORES; c++) begin
                if (!found_s && core_tx_req[c] && (idx_s == c)) begin
                    found_s     = 1'b1;
                    grant_s     = 4'(c);
                    onehot_s[c] = 1'b1;
                    grant_pkt_s = {core_tx_dest_node[c*8 +: 8], core_tx_dest_core[c*4 +: 4],
                                   4'(c), core_tx_data[c*16 +: 16]};
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Transmit FSM; ack pulses alongside the first cycle the granted packet is presented.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            rr_ptr_r    <= 4'd0;
            grant_r     <= 4'd0;
            tx_packet_r <= 32'd0;
            tx_valid_r  <= 1'b0;
            tx_ack_r    <= {NUM_CORES{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_r     <= SEND;
                        grant_r     <= grant_s;
                        tx_packet_r <= grant_pkt_s;
                        tx_valid_r  <= 1'b1;
                        tx_ack_r    <= onehot_s;
                    end else begin
                        tx_valid_r  <= 1'b0;
                        tx_ack_r    <= {NUM_CORES{1'b0}};
                    end
                end
                SEND: begin
                    tx_ack_r <= {NUM_CORES{1'b0}};
                    if (data_tx_ready) begin
                        state_r    <= IDLE;
                        tx_valid_r <= 1'b0;
                        rr_ptr_r   <= (grant_r == 4'(NUM_CORES - 1)) ? 4'd0 : grant_r + 4'd1;
                    end else begin
                        tx_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    tx_valid_r <= 1'b0;
                    tx_ack_r   <= {NUM_CORES{1'b0}};
                end
            endcase
        end
    end

    assign data_tx_packet = tx_packet_r;
    assign data_tx_valid  = tx_valid_r;
    assign core_tx_ack    = tx_ack_r;

    logic                   rx_hit_s;
    logic                   bad_core_s;
    logic                   drop_s;
    logic [NUM_CORES-1:0]   sel_s;
    logic [NUM_CORES-1:0]   fifo_drop_s;
    logic [15:0]            drop_cnt_r;
    logic                   unused_node_s;

    assign unused_node_s = ^node_id[15:8];
    assign rx_hit_s      = data_rx_valid && (data_rx_packet[31:24] == node_id[7:0]);
    assign bad_core_s    = ({28'd0, data_rx_packet[23:20]} >= 32'(NUM_CORES));
    assign drop_s        = rx_hit_s && (bad_core_s || (|fifo_drop_s));

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_rx
        logic [19:0] mem_r [RX_DEPTH];
        logic [AW:0] wr_ptr_r;
        logic [AW:0] rd_ptr_r;
        logic        empty_s;
        logic        full_s;
        logic        pop_s;
        logic        push_s;

        assign sel_s[i]       = rx_hit_s && (data_rx_packet[23:20] == 4'(i));
        assign empty_s        = (wr_ptr_r == rd_ptr_r);
        assign full_s         = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
        assign pop_s          = core_rx_read[i] && !empty_s;
        assign push_s         = sel_s[i] && (!full_s || pop_s);
        assign fifo_drop_s[i] = sel_s[i] && full_s && !pop_s;

        // Pointer update; a pop frees the slot a same-cycle push into a full FIFO needs.
        always_ff @(posedge clk) begin
            if (!rst) begin
                wr_ptr_r <= {(AW+1){1'b0}};
                rd_ptr_r <= {(AW+1){1'b0}};
            end else begin
                wr_ptr_r <= push_s ? wr_ptr_r + {{AW{1'b0}}, 1'b1} : wr_ptr_r;
                rd_ptr_r <= pop_s  ? rd_ptr_r + {{AW{1'b0}}, 1'b1} : rd_ptr_r;
            end
        end

        // Storage write: {src core, payload}.
        always_ff @(posedge clk) begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= data_rx_packet[19:0];
            end else begin
                mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
            end
        end

        assign core_rx_valid[i]           = !empty_s;
        assign core_rx_data[i*16 +: 16]   = mem_r[rd_ptr_r[AW-1:0]][15:0];
        assign core_rx_src_core[i*4 +: 4] = mem_r[rd_ptr_r[AW-1:0]][19:16];
    end

    // Saturating count of local packets that could not be delivered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign rx_drop_count = drop_cnt_r;

endmodule

// File: tb/tb_computer_cluster_port.sv
// Directed bench for computer_cluster_port: TX arbitration/stall/reset and RX FIFO
// delivery/drop behaviour, checked against expected-value queues.
module tb_computer_cluster_port;
    localparam int NC    = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       node_id;
    logic [NC-1:0]     core_tx_req;
    logic [NC*8-1:0]   core_tx_dest_node;
    logic [NC*4-1:0]   core_tx_dest_core;
    logic [NC*16-1:0]  core_tx_data;
    logic [NC-1:0]     core_tx_ack;
    logic [31:0]       data_tx_packet;
    logic              data_tx_valid;
    logic              data_tx_ready;
    logic [31:0]       data_rx_packet;
    logic              data_rx_valid;
    logic [NC-1:0]     core_rx_valid;
    logic [NC*16-1:0]  core_rx_data;
    logic [NC*4-1:0]   core_rx_src_core;
    logic [NC-1:0]     core_rx_read;
    logic [15:0]       rx_drop_count;

    logic [19:0] rxq [NC][$];
    logic [31:0] txq [$];
    logic [31:0] held;
    int checks = 0;
    int errors = 0;
    int exp_drop = 0;

    computer_cluster_port #(.NUM_CORES(NC), .RX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .node_id(node_id),
        .core_tx_req(core_tx_req), .core_tx_dest_node(core_tx_dest_node),
        .core_tx_dest_core(core_tx_dest_core), .core_tx_data(core_tx_data),
        .core_tx_ack(core_tx_ack), .data_tx_packet(data_tx_packet),
        .data_tx_valid(data_tx_valid), .data_tx_ready(data_tx_ready),
        .data_rx_packet(data_rx_packet), .data_rx_valid(data_rx_valid),
        .core_rx_valid(core_rx_valid), .core_rx_data(core_rx_data),
        .core_rx_src_core(core_rx_src_core), .core_rx_read(core_rx_read),
        .rx_drop_count(rx_drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_pkt(input int c);
        logic [3:0] cc;
        cc = 4'(c);
        return {8'h10 + 8'(c), cc ^ 4'h5, cc, 16'hA000 + 16'(c)};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        core_tx_req = '0; data_tx_ready = 1'b0;
        data_rx_valid = 1'b0; data_rx_packet = 32'd0; core_rx_read = '0;
        tick();
        tick();
        chk("rst_tx_valid", 32'(data_tx_valid), 32'd0);
        chk("rst_tx_ack", 32'(core_tx_ack), 32'd0);
        chk("rst_tx_pkt", data_tx_packet, 32'd0);
        chk("rst_rx_valid", 32'(core_rx_valid), 32'd0);
        chk("rst_drop", 32'(rx_drop_count), 32'd0);
        rst = 1'b1;
        for (int c = 0; c < NC; c++) rxq[c].delete();
        txq.delete();
        exp_drop = 0;
    endtask

    // Compare current RX outputs with the model, then apply one cycle of stimulus.
    task automatic rx_cycle(input logic [31:0] pkt, input logic vld, input logic [NC-1:0] rd);
        logic [3:0] dc;
        data_rx_packet = pkt; data_rx_valid = vld; core_rx_read = rd;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("rx_valid%0d", c), 32'(core_rx_valid[c]), 32'(rxq[c].size() != 0));
            if (rxq[c].size() != 0) begin
                chk($sformatf("rx_data%0d", c), 32'(core_rx_data[c*16 +: 16]), 32'(rxq[c][0][15:0]));
                chk($sformatf("rx_src%0d", c), 32'(core_rx_src_core[c*4 +: 4]), 32'(rxq[c][0][19:16]));
            end
        end
        chk("rx_drop", 32'(rx_drop_count), 32'(exp_drop));
        for (int c = 0; c < NC; c++)
            if (rd[c] && rxq[c].size() != 0) void'(rxq[c].pop_front());
        dc = pkt[23:20];
        if (vld && pkt[31:24] == node_id[7:0]) begin
            if (int'(dc) >= NC || rxq[dc].size() >= DEPTH) begin
                if (exp_drop < 65535) exp_drop++;
            end else begin
                rxq[dc].push_back(pkt[19:0]);
            end
        end
        tick();
        data_rx_valid = 1'b0; data_rx_packet = 32'd0; core_rx_read = '0;
    endtask

    initial begin
        node_id = 16'hAB03;
        for (int c = 0; c < NC; c++) begin
            core_tx_dest_node[c*8 +: 8] = 8'h10 + 8'(c);
            core_tx_dest_core[c*4 +: 4] = 4'(c) ^ 4'h5;
            core_tx_data[c*16 +: 16]    = 16'hA000 + 16'(c);
        end
        do_reset();

        // Two requesters held, link always ready: alternate grants, valid every other cycle.
        for (int k = 0; k < 4; k++) txq.push_back(exp_pkt((k % 2) * 2));
        core_tx_req = 4'b0101; data_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
                chk("rr_valid", 32'(data_tx_valid), 32'd1);
                chk("rr_ack", 32'(core_tx_ack), (i % 4 == 0) ? 32'h1 : 32'h4);
                chk("rr_pkt", data_tx_packet, txq.pop_front());
            end else begin
                chk("rr_idle_valid", 32'(data_tx_valid), 32'd0);
                chk("rr_idle_ack", 32'(core_tx_ack), 32'd0);
            end
        end
        core_tx_req = '0;

        // Grant core1 into a stalled link, then reset mid-SEND.
        core_tx_req = 4'b0010; data_tx_ready = 1'b0;
        txq.push_back(exp_pkt(1));
        tick();
        held = txq.pop_front();
        chk("stall_ack", 32'(core_tx_ack), 32'h2);
        chk("stall_valid", 32'(data_tx_valid), 32'd1);
        chk("stall_pkt", data_tx_packet, held);
        core_tx_req = '0;
        tick();
        chk("stall_ack_once", 32'(core_tx_ack), 32'd0);
        chk("stall_hold_valid", 32'(data_tx_valid), 32'd1);
        chk("stall_hold_pkt", data_tx_packet, held);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_valid", 32'(data_tx_valid), 32'd0);
        chk("abort_ack", 32'(core_tx_ack), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("no_reack", 32'(core_tx_ack), 32'd0);
        chk("no_resend", 32'(data_tx_valid), 32'd0);
        // rr_ptr back at 0: cores 1 and 3 requesting must grant core1.
        core_tx_req = 4'b1010; data_tx_ready = 1'b1;
        txq.push_back(exp_pkt(1));
        txq.push_back(exp_pkt(3));
        tick();
        chk("rr_after_rst_ack", 32'(core_tx_ack), 32'h2);
        chk("rr_after_rst_pkt", data_tx_packet, txq.pop_front());
        core_tx_req = 4'b1000;
        tick();
        chk("gap_valid", 32'(data_tx_valid), 32'd0);
        tick();
        chk("next_ack", 32'(core_tx_ack), 32'h8);
        chk("next_pkt", data_tx_packet, txq.pop_front());
        core_tx_req = '0;
        tick();

        // RX delivery, foreign node, bad core, read of empty FIFO.
        do_reset();
        rx_cycle(32'h0312ABCD, 1'b1, 4'b0000);
        rx_cycle(32'h0, 1'b0, 4'b0000);
        rx_cycle(32'h07011111, 1'b1, 4'b0000);
        rx_cycle(32'h03F02222, 1'b1, 4'b0000);
        rx_cycle(32'h03231234, 1'b1, 4'b0010);
        rx_cycle(32'h0, 1'b0, 4'b1000);
        rx_cycle(32'h0, 1'b0, 4'b0100);
        rx_cycle(32'h0, 1'b0, 4'b0000);

        // Overflow of core0's FIFO, then push+pop on the full FIFO.
        do_reset();
        for (int k = 0; k < 5; k++)
            rx_cycle({8'h03, 4'h0, 4'(k), 16'h1000 + 16'(k)}, 1'b1, 4'b0000);
        rx_cycle(32'h0, 1'b0, 4'b0000);
        rx_cycle(32'h03075555, 1'b1, 4'b0001);
        for (int k = 0; k < 5; k++)
            rx_cycle(32'h0, 1'b0, 4'b0001);
        rx_cycle(32'h0, 1'b0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
